dds_iq_model: RTL and testbench
===============================

# dds_iq_model

Behavioural RTL model of the numerically controlled oscillator that sits between the marga core's DDS control outputs and its `ddsN_iq_axis_tdata_i` inputs. The model accumulates a phase step and applies a streamed phase offset. It converts the resulting phase to a quadrature cos/sin sample through a sine ROM, producing one 32-bit I/Q word per clock. In the Verilator top-level, three instances (dds0..dds2) close the loop in place of the vendor DDS cores.

## Interface
Parameters:
- none; all widths are fixed by the marga DDS ports.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `phase_step_i`  in  31  per-cycle phase increment, unsigned; zero-extended to 32 bits.
- `phase_clear_i`  in  1  level; while high, the accumulator is forced to 0.
- `phase_axis_tdata_i`  in  24  phase offset, unsigned, in units of 2^-24 cycle.
- `phase_axis_tvalid_i`  in  1  loads the offset register; there is no tready, so the input is always accepted.
- `iq_axis_tdata_o`  out  32  output sample, packed as {q[15:0], i[15:0]}; two's complement; i = cos, q = sin.
- `iq_axis_tvalid_o`  out  1  output valid; there is no backpressure.

## Operation
Sine table:
- T[j], j = 0..255, equals round(32767·sin(2π(j+0.5)/1024)).
- T[0] = 101 and T[255] = 32767.
- No entry is 0 or -32768, so negation never overflows.

Pipeline, one sample per clock:
- S1: `acc` (32 bit) is updated as follows.
  - If `phase_clear_i` is high, `acc` ← 0.
  - Otherwise, `acc` ← `acc` + {1'b0, `phase_step_i`}, modulo 2^32.
  - Clear has priority over step.
- S1 (in parallel): if `phase_axis_tvalid_i` is high, `offset` ← `phase_axis_tdata_i`; otherwise `offset` holds.
- S2: `pw` (24 bit) ← `acc`[31:8] + `offset`, modulo 2^24.
- S3: the sine and cosine indices are registered.
  - Sine index: `idx` = `pw`[23:14].
  - Cosine index: `idx` + 256, modulo 1024.
  - Each index is split into a quadrant `qd` = bits [9:8] and `j` = bits [7:0].
  - The ROM value is read for each index.
    - For qd 0 or 2, read T[j].
    - For qd 1 or 3, read T[255-j].
- S4: the output is registered.
  - Each value is negated if qd ≥ 2.
  - `i` and `q` are packed into `iq_axis_tdata_o`.

Valid generation:
- A 4-bit shift register is filled with 1s after reset.
- `iq_axis_tvalid_o` is its MSB.

Boundary conditions:
- Accumulator wrap: modulo arithmetic, with no saturation.
- The maximum step, 0x7FFFFFFF, is just under half a cycle per sample.
- `phase_clear_i` and `phase_axis_tvalid_i` in the same cycle: both take effect on the same edge.
- `phase_clear_i` held high: output is constant at the value for index `offset`[23:14].

## Timing
- Reset values: `acc`, `offset`, `pw`, the S3 registers, `iq_axis_tdata_o` = 0, `iq_axis_tvalid_o` = 0.
- Reset mid-operation:
  - All registers clear on the next edge.
  - `tvalid` drops on that edge.
  - `tvalid` rises again on the 4th edge after `rst` is sampled low.
- Latency is measured from the edge that samples a new `phase_step_i`, `phase_clear_i`, or `phase_axis_tdata_i`.
  - The first output word reflecting it appears after the 3rd following edge (edge n+3).
  - All three inputs have equal latency.
- Throughput: one word per clock, continuous.
- `tvalid` stays high until the next reset.

## Configuration
`DDS_IQ_MODEL_QUARTER_WAVE_EN`:
- Defined: a single 256-entry T ROM with quadrant folding and negation, as described under Operation.
- Undefined:
  - Two 1024-entry ROMs (sin and cos) are indexed directly by `idx` in S3.
  - They are built at elaboration from the same T values using the folding rule.
  - S4 only registers the values, with no negation.
- Both variants must be bit-identical with identical latency.

## Test plan
- Reset released, step 0, offset 0: `tvalid` rises on the 4th edge; `tdata` = 0x00657FFF (i=32767, q=101) thereafter.
- `phase_axis_tdata_i` = 0x400000 with one `tvalid` pulse: 3 edges later `tdata` = 0x7FFFFF9B (i=-101, q=32767).
- Step 0x01000000: the index advances by 4 per sample; the output sequence repeats with a period of exactly 256 samples, and sample k equals ROM(4k).
- Step running, a 1-cycle `phase_clear_i` pulse: the output after edge n+3 is 0x00657FFF (offset 0), then advances by the step again from the next sample.
- Step 0x7FFFFFFF from 0: the index sequence is 0, 511, 1023, 511 (accumulator wrap check).
- `rst` asserted mid-stream for 2 cycles: `tdata` = 0 and `tvalid` = 0 from the next edge; `tvalid` returns 4 edges after release, restarting at index 0.

Source files
------------

// File: rtl/dds_iq_model.sv
// dds_iq_model: phase-accumulator NCO with a streamed phase offset, producing one {sin, cos} word per clock.
// Build option DDS_IQ_MODEL_QUARTER_WAVE_EN: one folded 256-entry ROM; otherwise two direct 1024-entry ROMs.
module dds_iq_model (
    input  logic        clk,
    input  logic        rst,
    input  logic [30:0] phase_step_i,
    input  logic        phase_clear_i,
    input  logic [23:0] phase_axis_tdata_i,
    input  logic        phase_axis_tvalid_i,
    output logic [31:0] iq_axis_tdata_o,
    output logic        iq_axis_tvalid_o
);

    // Quarter-wave entry T[j] = round(32767*sin(2*pi*(j+0.5)/1024)), evaluated at elaboration.
    function automatic logic [15:0] quarter_sine(input int j);
        real x, term, sum;
        x    = 2.0 * 3.14159265358979323846 * (real'(j) + 0.5) / 1024.0;
        term = x;
        sum  = x;
        for (int k = 1; k < 14; k++) begin
            term = -term * x * x / real'((2 * k) * (2 * k + 1));
            sum  = sum + term;
        end
        return 16'($rtoi(32767.0 * sum + 0.5));
    endfunction

    logic [31:0] acc_q, acc_d;
    logic [23:0] off_q, off_d;
    logic [23:0] pw_q, pw_d;
    logic [15:0] sin_val_q, sin_val_d;
    logic [15:0] cos_val_q, cos_val_d;
    logic [31:0] iq_q, iq_d;
    logic [3:0]  vld_q, vld_d;
    logic [9:0]  idx_sin;

    assign idx_sin = pw_q[23:14];

    always_comb begin
        acc_d = acc_q + {1'b0, phase_step_i};
        if (phase_clear_i) begin
            acc_d = '0;
        end
        off_d = phase_axis_tvalid_i ? phase_axis_tdata_i : off_q;
        pw_d  = acc_q[31:8] + off_q;
        vld_d = {vld_q[2:0], 1'b1};
    end

`ifdef DDS_IQ_MODEL_QUARTER_WAVE_EN
    logic [15:0] t_rom [256];
    logic [9:0]  idx_cos;
    logic [7:0]  j_sin, j_cos;
    logic        sin_neg_q, sin_neg_d;
    logic        cos_neg_q, cos_neg_d;

    for (genvar gi = 0; gi < 256; gi++) begin : g_t_rom
        localparam logic [15:0] TV = quarter_sine(gi);
        assign t_rom[gi] = TV;
    end

    // Odd quadrants walk the table backwards: 255-j is just the bitwise complement of j.
    always_comb begin
        idx_cos   = idx_sin + 10'd256;
        j_sin     = idx_sin[8] ? ~idx_sin[7:0] : idx_sin[7:0];
        j_cos     = idx_cos[8] ? ~idx_cos[7:0] : idx_cos[7:0];
        sin_val_d = t_rom[j_sin];
        cos_val_d = t_rom[j_cos];
        sin_neg_d = idx_sin[9];
        cos_neg_d = idx_cos[9];
        iq_d      = {(sin_neg_q ? 16'(-sin_val_q) : sin_val_q),
                     (cos_neg_q ? 16'(-cos_val_q) : cos_val_q)};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sin_neg_q <= 1'b0;
            cos_neg_q <= 1'b0;
        end else begin
            sin_neg_q <= sin_neg_d;
            cos_neg_q <= cos_neg_d;
        end
    end
`else
    function automatic logic [15:0] full_sine(input int idx);
        int          qd, j;
        logic [15:0] t;
        qd = (idx / 256) % 4;
        j  = idx % 256;
        t  = quarter_sine((qd % 2 == 1) ? 255 - j : j);
        return (qd >= 2) ? 16'(-t) : t;
    endfunction

    logic [15:0] sin_rom [1024];
    logic [15:0] cos_rom [1024];

    for (genvar gi = 0; gi < 1024; gi++) begin : g_full_rom
        localparam logic [15:0] SV = full_sine(gi);
        localparam logic [15:0] CV = full_sine((gi + 256) % 1024);
        assign sin_rom[gi] = SV;
        assign cos_rom[gi] = CV;
    end

    always_comb begin
        sin_val_d = sin_rom[idx_sin];
        cos_val_d = cos_rom[idx_sin];
        iq_d      = {sin_val_q, cos_val_q};
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q     <= '0;
            off_q     <= '0;
            pw_q      <= '0;
            sin_val_q <= '0;
            cos_val_q <= '0;
            iq_q      <= '0;
            vld_q     <= '0;
        end else begin
            acc_q     <= acc_d;
            off_q     <= off_d;
            pw_q      <= pw_d;
            sin_val_q <= sin_val_d;
            cos_val_q <= cos_val_d;
            iq_q      <= iq_d;
            vld_q     <= vld_d;
        end
    end

    assign iq_axis_tdata_o  = iq_q;
    assign iq_axis_tvalid_o = vld_q[3];

endmodule

// File: tb/tb_dds_iq_model.sv
// Self-checking bench for dds_iq_model: directed scenarios plus random stimulus against a phase/trig model.
module tb_dds_iq_model;

    localparam real PI = 3.14159265358979323846;

    logic        clk = 1'b0;
    logic        rst;
    logic [30:0] step;
    logic        clr;
    logic [23:0] odata;
    logic        ovalid;
    logic [31:0] tdata;
    logic        tvalid;

    always #5 clk = ~clk;

    dds_iq_model dut (
        .clk                 (clk),
        .rst                 (rst),
        .phase_step_i        (step),
        .phase_clear_i       (clr),
        .phase_axis_tdata_i  (odata),
        .phase_axis_tvalid_i (ovalid),
        .iq_axis_tdata_o     (tdata),
        .iq_axis_tvalid_o    (tvalid)
    );

    int          checks = 0;
    int          errors = 0;
    int          cycle  = 0;
    logic [31:0] acc_m;
    logic [23:0] off_m;
    logic [9:0]  hist [4];
    int          since_rst;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got 0x%08h expected 0x%08h", tag, cycle, got, exp);
        end
    endtask

    function automatic int rnd(input real v);
        if (v >= 0.0) return $rtoi(v + 0.5);
        return -$rtoi(-v + 0.5);
    endfunction

    // Ideal quadrature sample at the centre of a 1024-step phase bin.
    function automatic logic [31:0] ref_word(input logic [9:0] idx);
        real         th;
        int          s, c;
        logic [15:0] sv, cv;
        th = 2.0 * PI * (real'(idx) + 0.5) / 1024.0;
        s  = rnd(32767.0 * $sin(th));
        c  = rnd(32767.0 * $cos(th));
        sv = 16'(s);
        cv = 16'(c);
        return {sv, cv};
    endfunction

    task automatic tick();
        logic [23:0] pw;
        logic        exp_v;
        @(posedge clk);
        cycle++;
        if (rst) begin
            acc_m     = '0;
            off_m     = '0;
            since_rst = 0;
        end else begin
            acc_m = clr ? 32'd0 : acc_m + {1'b0, step};
            if (ovalid) off_m = odata;
            if (since_rst < 1000) since_rst++;
        end
        pw = acc_m[31:8] + off_m;
        for (int k = 3; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = pw[23:14];
        #1;
        exp_v = !rst && (since_rst >= 4);
        check("tvalid", {31'd0, tvalid}, {31'd0, exp_v});
        if (rst) check("tdata_in_reset", tdata, 32'd0);
        else if (exp_v) check("tdata", tdata, ref_word(hist[3]));
        $display("cyc %0d rst=%0b step=%08h clr=%0b off=%0b/%06h -> tvalid=%0b tdata=%08h",
                 cycle, rst, step, clr, ovalid, odata, tvalid, tdata);
    endtask

    initial begin
        rst = 1'b1; step = '0; clr = 1'b0; odata = '0; ovalid = 1'b0;
        acc_m = '0; off_m = '0; since_rst = 0;
        for (int k = 0; k < 4; k++) hist[k] = '0;

        repeat (3) tick();
        rst = 1'b0;
        repeat (4) tick();
        check("first_valid_word", tdata, 32'h00657FFF);
        repeat (2) tick();

        // Offset of a quarter cycle
        odata = 24'h400000; ovalid = 1'b1;
        tick();
        ovalid = 1'b0;
        repeat (3) tick();
        check("offset_quarter", tdata, 32'h7FFFFF9B);

        // Back to zero offset, restart accumulator, step of 4 indices per sample
        odata = 24'h0; ovalid = 1'b1; clr = 1'b1;
        tick();
        ovalid = 1'b0; clr = 1'b0; step = 31'h01000000;
        repeat (300) tick();

        // One-cycle clear while stepping
        clr = 1'b1;
        tick();
        clr = 1'b0;
        repeat (3) tick();
        check("clear_pulse", tdata, 32'h00657FFF);
        tick();
        check("after_clear", tdata, ref_word(10'd4));

        // Maximum step: accumulator wrap
        step = 31'h7FFFFFFF; clr = 1'b1;
        tick();
        clr = 1'b0;
        repeat (3) tick();
        check("maxstep_idx0", tdata, ref_word(10'd0));
        tick();
        check("maxstep_idx511", tdata, ref_word(10'd511));
        tick();
        check("maxstep_idx1023", tdata, ref_word(10'd1023));
        tick();
        check("maxstep_idx511b", tdata, ref_word(10'd511));

        // Clear and offset load on the same edge
        clr = 1'b1; ovalid = 1'b1; odata = 24'hC00000;
        tick();
        ovalid = 1'b0;
        repeat (4) tick();
        check("clear_hold_offset", tdata, ref_word(10'd768));
        clr = 1'b0;

        // Random stimulus, including occasional short resets
        for (int n = 0; n < 500; n++) begin
            step   = 31'($urandom);
            if ($urandom_range(0, 3) == 0) step = 31'($urandom_range(0, 65535));
            clr    = ($urandom_range(0, 9) == 0);
            ovalid = ($urandom_range(0, 4) == 0);
            odata  = 24'($urandom);
            rst    = ($urandom_range(0, 49) == 0);
            tick();
        end
        rst = 1'b0; clr = 1'b0; ovalid = 1'b0;

        // Reset in the middle of a running stream
        step = 31'h01000000;
        repeat (10) tick();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0; step = '0;
        repeat (3) tick();
        tick();
        check("restart_after_reset", tdata, 32'h00657FFF);
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
